// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and hazard/stall unit for the in-order pipeline.
// Tracks in-flight destinations per stage and a scoreboard of outstanding long-latency ops.
module fwd_hazard_scoreboard #(
  parameter int NUM_RS     = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LONG_MAX   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       id_valid,
  input  logic [NUM_RS*REG_AW-1:0]                   id_rs_addr,
  input  logic [NUM_RS-1:0]                          id_rs_used,
  input  logic [REG_AW-1:0]                          id_rd_addr,
  input  logic                                       id_reg_write,
  input  logic                                       id_is_load,
  input  logic                                       id_is_long,
  input  logic                                       pipe_advance,
  input  logic                                       flush,
  input  logic                                       long_done,
  input  logic [REG_AW-1:0]                          long_done_rd,
  output logic [NUM_RS*$clog2(FWD_STAGES+1)-1:0]     fwd_sel,
  output logic                                       stall,
  output logic [$clog2(LONG_MAX+1)-1:0]              long_cnt,
  output logic                                       long_full
);

  localparam int FSEL_W = $clog2(FWD_STAGES + 1);
  localparam int CNT_W  = $clog2(LONG_MAX + 1);
  localparam int NREG   = 1 << REG_AW;

  logic [FWD_STAGES-1:0]             r_stg_vld;
  logic [FWD_STAGES-1:0]             r_stg_ld;
  logic [FWD_STAGES-1:0][REG_AW-1:0] r_stg_rd;
  logic [NREG-1:0]                   r_pend;
  logic [CNT_W-1:0]                  r_long_cnt;

  logic [REG_AW-1:0]          w_rs [NUM_RS];
  logic [NUM_RS-1:0]          w_rs_chk;
  logic [NREG-1:0]            w_done_oh;
  logic [NREG-1:0]            w_set_oh;
  logic [NREG-1:0]            w_pend_eff;
  logic [NREG-1:0]            w_pend_nxt;
  logic [NUM_RS*FSEL_W-1:0]   w_fwd_sel;
  logic                       w_rd_nz;
  logic                       w_long_full;
  logic                       w_done_hit;
  logic                       w_stall_raw;
  logic                       w_stall;
  logic                       w_accept;
  logic                       w_long_acc;
  logic                       w_new_vld;

  // ID-stage decode: per-port source address and whether it needs checking
  for (genvar g = 0; g < NUM_RS; g++) begin : g_port
    assign w_rs[g]     = id_rs_addr[g*REG_AW +: REG_AW];
    assign w_rs_chk[g] = id_rs_used[g] & (w_rs[g] != '0);
  end

  assign w_rd_nz     = (id_rd_addr != '0);
  assign w_long_full = (r_long_cnt == CNT_W'(LONG_MAX));
  assign w_done_hit  = long_done & r_pend[long_done_rd];
  assign w_done_oh   = long_done ? (NREG'(1) << long_done_rd) : '0;
  // A same-cycle completion is visible through register-file write-through.
  assign w_pend_eff  = r_pend & ~w_done_oh;

  always_comb begin
    w_fwd_sel   = '0;
    w_stall_raw = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      // Scan oldest to youngest so the youngest matching stage wins.
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (w_rs_chk[i] && r_stg_vld[k] && (r_stg_rd[k] == w_rs[i]))
          w_fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
      end
      if (w_rs_chk[i] && r_stg_vld[0] && r_stg_ld[0] && (r_stg_rd[0] == w_rs[i]))
        w_stall_raw = 1'b1;
      if (w_rs_chk[i] && w_pend_eff[w_rs[i]])
        w_stall_raw = 1'b1;
    end
    if (id_reg_write && w_rd_nz && w_pend_eff[id_rd_addr])
      w_stall_raw = 1'b1;
    if (id_is_long && w_long_full)
      w_stall_raw = 1'b1;
  end

  assign w_stall    = id_valid & ~flush & ~rst & w_stall_raw;
  assign w_accept   = id_valid & pipe_advance & ~w_stall & ~flush;
  assign w_long_acc = w_accept & id_is_long & id_reg_write & w_rd_nz;
  assign w_new_vld  = w_accept & id_reg_write & w_rd_nz & ~id_is_long;
  assign w_set_oh   = w_long_acc ? (NREG'(1) << id_rd_addr) : '0;
  assign w_pend_nxt = w_pend_eff | w_set_oh;

  assign fwd_sel   = rst ? '0 : w_fwd_sel;
  assign stall     = w_stall;
  assign long_cnt  = r_long_cnt;
  assign long_full = w_long_full;

  // Stage boundary: ID -> EXE and onward shift of in-flight destinations
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_vld <= '0;
      r_stg_ld  <= '0;
      r_stg_rd  <= '0;
    end else if (pipe_advance) begin
      for (int k = FWD_STAGES - 1; k >= 1; k--) begin
        r_stg_vld[k] <= r_stg_vld[k-1];
        r_stg_ld[k]  <= r_stg_ld[k-1];
        r_stg_rd[k]  <= r_stg_rd[k-1];
      end
      r_stg_vld[0] <= w_new_vld;
      r_stg_ld[0]  <= id_is_load;
      r_stg_rd[0]  <= id_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_long_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      case ({w_long_acc, w_done_hit})
        2'b10:   if (!w_long_full) r_long_cnt <= r_long_cnt + CNT_W'(1);
        2'b01:   if (r_long_cnt != '0) r_long_cnt <= r_long_cnt - CNT_W'(1);
        default: r_long_cnt <= r_long_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: directed vector table, reset-mid-flight sequence,
// then random traffic against a queue/set based reference model.
module tb_fwd_hazard_scoreboard;

  localparam int NUM_RS     = 2;
  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 2;
  localparam int LONG_MAX   = 4;
  localparam int FSEL_W     = 2;
  localparam int CNT_W      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic                        id_valid;
  logic [NUM_RS*REG_AW-1:0]    id_rs_addr;
  logic [NUM_RS-1:0]           id_rs_used;
  logic [REG_AW-1:0]           id_rd_addr;
  logic                        id_reg_write;
  logic                        id_is_load;
  logic                        id_is_long;
  logic                        pipe_advance;
  logic                        flush;
  logic                        long_done;
  logic [REG_AW-1:0]           long_done_rd;
  logic [NUM_RS*FSEL_W-1:0]    fwd_sel;
  logic                        stall;
  logic [CNT_W-1:0]            long_cnt;
  logic                        long_full;

  fwd_hazard_scoreboard #(
    .NUM_RS(NUM_RS), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LONG_MAX(LONG_MAX)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_long(id_is_long), .pipe_advance(pipe_advance),
    .flush(flush), .long_done(long_done), .long_done_rd(long_done_rd),
    .fwd_sel(fwd_sel), .stall(stall), .long_cnt(long_cnt), .long_full(long_full)
  );

  typedef struct {
    bit rst; bit vld; int rs0; int rs1; bit [1:0] used; int rd;
    bit wr; bit ld; bit lng; bit adv; bit fl; bit dn; int dnrd;
    int e_sel0; int e_sel1; bit e_stall; int e_cnt;
  } vec_t;

  typedef struct { bit v; int rd; bit ld; } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t m_pipe[$];
  bit   m_pend[int];
  vec_t tbl[$];

  function automatic vec_t mk(bit rs_, bit vld, int rs0, int rs1, bit [1:0] used, int rd,
                              bit wr, bit ld, bit lng, bit adv, bit fl, bit dn, int dnrd,
                              int s0, int s1, bit st, int cnt);
    vec_t v;
    v.rst = rs_; v.vld = vld; v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.rd = rd;
    v.wr = wr; v.ld = ld; v.lng = lng; v.adv = adv; v.fl = fl; v.dn = dn; v.dnrd = dnrd;
    v.e_sel0 = s0; v.e_sel1 = s1; v.e_stall = st; v.e_cnt = cnt;
    return v;
  endfunction

  // Reference model: in-flight queue (front = EXE) and a set of pending long destinations.
  function automatic void m_reset();
    ent_t b;
    b.v = 1'b0; b.rd = 0; b.ld = 1'b0;
    m_pend.delete();
    m_pipe.delete();
    for (int k = 0; k < FWD_STAGES; k++) m_pipe.push_back(b);
  endfunction

  function automatic int m_sel(int rs, bit used);
    if (!used || rs == 0) return 0;
    for (int k = 0; k < m_pipe.size(); k++)
      if (m_pipe[k].v && m_pipe[k].rd == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit m_busy(int r, vec_t v);
    return m_pend.exists(r) && !(v.dn && v.dnrd == r);
  endfunction

  function automatic bit m_stall(vec_t v);
    int rs;
    if (v.rst || !v.vld || v.fl) return 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs = (i == 0) ? v.rs0 : v.rs1;
      if (v.used[i] && rs != 0) begin
        if (m_pipe[0].v && m_pipe[0].ld && m_pipe[0].rd == rs) return 1'b1;
        if (m_busy(rs, v)) return 1'b1;
      end
    end
    if (v.wr && v.rd != 0 && m_busy(v.rd, v)) return 1'b1;
    if (v.lng && m_pend.num() == LONG_MAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_step(vec_t v);
    bit   acc;
    ent_t e;
    if (v.rst) begin
      m_reset();
      return;
    end
    acc = v.vld && v.adv && !m_stall(v) && !v.fl;
    if (v.dn && m_pend.exists(v.dnrd)) m_pend.delete(v.dnrd);
    if (acc && v.lng && v.wr && v.rd != 0) m_pend[v.rd] = 1'b1;
    if (v.adv) begin
      e.v  = acc && v.wr && v.rd != 0 && !v.lng;
      e.rd = v.rd;
      e.ld = v.ld;
      m_pipe.push_front(e);
      void'(m_pipe.pop_back());
    end
  endfunction

  function automatic vec_t m_expect(vec_t v);
    vec_t r = v;
    r.e_sel0  = v.rst ? 0 : m_sel(v.rs0, v.used[0]);
    r.e_sel1  = v.rst ? 0 : m_sel(v.rs1, v.used[1]);
    r.e_stall = m_stall(v);
    r.e_cnt   = m_pend.num();
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst          = v.rst;
    id_valid     = v.vld;
    id_rs_addr   = {REG_AW'(v.rs1), REG_AW'(v.rs0)};
    id_rs_used   = v.used;
    id_rd_addr   = REG_AW'(v.rd);
    id_reg_write = v.wr;
    id_is_load   = v.ld;
    id_is_long   = v.lng;
    pipe_advance = v.adv;
    flush        = v.fl;
    long_done    = v.dn;
    long_done_rd = REG_AW'(v.dnrd);
  endtask

  // Drive just after posedge, compare at negedge, then let the edge commit.
  task automatic apply(vec_t v, string tag);
    drive(v);
    #4;
    chk({tag, ".sel0"},  int'(fwd_sel[FSEL_W-1:0]),        v.e_sel0);
    chk({tag, ".sel1"},  int'(fwd_sel[2*FSEL_W-1:FSEL_W]), v.e_sel1);
    chk({tag, ".stall"}, int'(stall),                      int'(v.e_stall));
    chk({tag, ".cnt"},   int'(long_cnt),                   v.e_cnt);
    chk({tag, ".full"},  int'(long_full),                  int'(v.e_cnt == LONG_MAX));
    m_step(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    //          rst vld rs0 rs1 used rd wr ld lng adv fl dn dnrd  s0 s1 st cnt
    tbl.push_back(mk(0,0, 0, 0,2'b00, 0,0,0,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 1, 2,2'b11, 5,1,0,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 5, 6,2'b11, 8,1,0,0,1,0,0, 0, 1,0,0,0));
    tbl.push_back(mk(0,1, 0, 5,2'b11, 9,1,0,0,1,0,0, 0, 0,2,0,0));
    tbl.push_back(mk(0,1, 1, 0,2'b01, 7,1,1,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 2, 7,2'b11,10,1,0,0,1,0,0, 0, 0,1,1,0));
    tbl.push_back(mk(0,1, 2, 7,2'b11,10,1,0,0,1,0,0, 0, 0,2,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b00,12,1,1,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b00,13,1,0,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1,12, 0,2'b01, 0,0,0,0,1,0,0, 0, 2,0,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b00, 3,1,0,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 3, 0,2'b01, 3,1,0,0,1,0,0, 0, 1,0,0,0));
    tbl.push_back(mk(0,1, 3, 3,2'b11, 0,1,0,0,1,0,0, 0, 1,1,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b11, 4,1,0,0,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 4, 4,2'b10, 0,0,0,0,1,0,0, 0, 0,1,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b00,10,1,0,1,1,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0,1, 0, 0,2'b00,11,1,0,1,1,0,0, 0, 0,0,0,1));
    tbl.push_back(mk(0,1, 0, 0,2'b00,12,1,0,1,1,0,0, 0, 0,0,0,2));
    tbl.push_back(mk(0,1, 0, 0,2'b00,13,1,0,1,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1, 0, 0,2'b00,14,1,0,1,1,0,0, 0, 0,0,1,4));
    tbl.push_back(mk(0,1, 0, 0,2'b00,14,1,0,1,1,0,1,11, 0,0,1,4));
    tbl.push_back(mk(0,1, 0, 0,2'b00,14,1,0,1,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1,10, 0,2'b01, 0,0,0,0,1,0,0, 0, 0,0,1,4));
    tbl.push_back(mk(0,1,10, 0,2'b01, 0,0,0,0,1,0,1,10, 0,0,0,4));
    tbl.push_back(mk(0,1, 0, 0,2'b00,12,1,0,0,1,0,0, 0, 0,0,1,3));
    tbl.push_back(mk(0,0, 0, 0,2'b00, 0,0,0,0,1,0,1,20, 0,0,0,3));
    tbl.push_back(mk(0,0, 0, 0,2'b00, 0,0,0,0,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1, 0, 0,2'b00,15,1,0,1,1,0,1,12, 0,0,0,3));
    tbl.push_back(mk(0,0, 0, 0,2'b00, 0,0,0,0,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1, 0, 0,2'b00, 6,1,0,0,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1, 0, 0,2'b00, 7,1,0,0,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1, 7, 6,2'b11, 8,1,0,0,0,0,0, 0, 1,2,0,3));
    tbl.push_back(mk(0,1, 7, 6,2'b11, 8,1,0,0,0,0,0, 0, 1,2,0,3));
    tbl.push_back(mk(0,1, 7, 6,2'b11, 8,1,0,0,0,0,0, 0, 1,2,0,3));
    tbl.push_back(mk(0,0, 7, 6,2'b11, 0,0,0,0,1,0,0, 0, 1,2,0,3));
    tbl.push_back(mk(0,1, 7, 0,2'b01,16,1,0,1,1,1,0, 0, 2,0,0,3));
    tbl.push_back(mk(0,0, 7,16,2'b11, 0,0,0,0,1,0,0, 0, 0,0,0,3));
    tbl.push_back(mk(0,1,13, 0,2'b01, 0,0,0,0,1,1,0, 0, 0,0,0,3));

    v = mk(1,0,0,0,2'b00,0,0,0,0,0,0,0,0, 0,0,0,0);
    drive(v);
    m_reset();
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of traffic with valid stages and pending long ops.
    apply(mk(0,1, 0, 0,2'b00,20,1,0,0,1,0,0, 0, 0,0,0,3), "rst_a");
    apply(mk(0,1,20, 0,2'b01,21,1,0,0,1,0,0, 0, 1,0,0,3), "rst_b");
    apply(mk(1,1,21,13,2'b11,22,1,1,0,1,0,0, 0, 0,0,0,3), "rst_c");
    apply(mk(0,1,21,13,2'b11, 0,0,0,0,1,0,1,13, 0,0,0,0), "rst_d");
    apply(mk(0,1,13,20,2'b11, 0,0,0,0,1,0,0, 0, 0,0,0,0), "rst_e");

    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 199) == 0);
      v.vld  = ($urandom_range(0, 7) != 0);
      v.rs0  = int'($urandom_range(0, 7));
      v.rs1  = int'($urandom_range(0, 7));
      v.used = 2'($urandom_range(0, 3));
      v.rd   = int'($urandom_range(0, 7));
      v.wr   = ($urandom_range(0, 3) != 0);
      v.ld   = ($urandom_range(0, 2) == 0);
      v.lng  = ($urandom_range(0, 5) == 0);
      v.adv  = ($urandom_range(0, 7) != 0);
      v.fl   = ($urandom_range(0, 9) == 0);
      v.dn   = ($urandom_range(0, 3) == 0);
      v.dnrd = int'($urandom_range(0, 7));
      v = m_expect(v);
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
